lzw_code_packer: RTL and testbench

- Downstream stage of the LZW encoder core. Consumes the 12-bit codes the core emits on each writeback and packs them MSB-first into a contiguous byte stream.
- Output side is a valid/ready byte interface toward the output buffer or host.
- On end-of-file, flushes the trailing partial byte, zero-padded, then signals done.
- The core has no stall input, so this block detects and flags overrun instead of back-pressuring.

---
 rtl/lzw_code_packer.sv | 135 +++++++++++++
 tb/tb_lzw_code_packer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lzw_code_packer.sv
// LZW code packer: packs fixed-width codes from the encoder core MSB-first
// into a byte stream on a valid/ready interface, pads the final partial byte
// on flush, and flags codes that arrive while it cannot take them.
module lzw_code_packer #(
    parameter int CODE_WIDTH = 12,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CODE_WIDTH-1:0] code_in,
    input  logic                  code_valid,
    output logic                  code_ready,
    input  logic                  flush,
    output logic [7:0]            byte_data,
    output logic                  byte_valid,
    input  logic                  byte_ready,
    output logic                  done,
    output logic                  overrun,
    output logic [CNT_WIDTH-1:0]  byte_count,
    output logic [CNT_WIDTH-1:0]  code_count
);

    localparam int ACC_WIDTH = CODE_WIDTH + 8;
    localparam int BCW       = $clog2(ACC_WIDTH);
    localparam logic [BCW-1:0] BYTE_BITS = BCW'(8);
    localparam logic [BCW-1:0] CODE_BITS = BCW'(CODE_WIDTH);

    typedef enum logic [1:0] {
        PACK,
        FLUSH,
        DONE
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [ACC_WIDTH-1:0] acc;
    logic [BCW-1:0]       bit_cnt;
    logic                 out_free;
    logic                 accept;
    logic                 emit_full;
    logic                 emit_pad;
    logic                 load;
    logic [ACC_WIDTH-1:0] full_shift;
    logic [ACC_WIDTH-1:0] pad_shift;
    logic [7:0]           next_byte;

    // Handshake qualifiers and the byte that would be loaded this cycle.
    // Accept needs fewer than 8 bits pending and emit needs at least 8,
    // so the two never happen together.
    always_comb begin
        out_free   = !byte_valid || byte_ready;
        code_ready = (state == PACK) && (bit_cnt < BYTE_BITS);
        accept     = code_valid && code_ready;
        emit_full  = out_free && (bit_cnt >= BYTE_BITS);
        emit_pad   = (state == FLUSH) && out_free && (bit_cnt != '0) && (bit_cnt < BYTE_BITS);
        load       = emit_full || emit_pad;
        full_shift = acc >> (bit_cnt - BYTE_BITS);
        pad_shift  = acc << (BYTE_BITS - bit_cnt);
        next_byte  = emit_pad ? pad_shift[7:0] : full_shift[7:0];
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= PACK;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: flush ends packing, DONE is reached once every
    // pending bit has left the output register; DONE is only left by reset.
    always_comb begin
        next_state = state;
        case (state)
            PACK: begin
                if (flush) begin
                    next_state = FLUSH;
                end
            end
            FLUSH: begin
                if ((bit_cnt == '0) && !byte_valid) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = DONE;
            end
            default: begin
                next_state = PACK;
            end
        endcase
    end

    assign done = (state == DONE);

    // Accumulator, output byte register, sticky overrun flag and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc        <= '0;
            bit_cnt    <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            overrun    <= 1'b0;
            byte_count <= '0;
            code_count <= '0;
        end else begin
            if (accept) begin
                acc        <= (acc << CODE_WIDTH) | ACC_WIDTH'(code_in);
                bit_cnt    <= bit_cnt + CODE_BITS;
                code_count <= code_count + 1'b1;
            end else if (emit_full) begin
                bit_cnt <= bit_cnt - BYTE_BITS;
            end else if (emit_pad) begin
                bit_cnt <= '0;
            end

            if (code_valid && !code_ready) begin
                overrun <= 1'b1;
            end

            if (byte_valid && byte_ready) begin
                byte_count <= byte_count + 1'b1;
            end

            if (load) begin
                byte_data  <= next_byte;
                byte_valid <= 1'b1;
            end else if (byte_ready) begin
                byte_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lzw_code_packer.sv
// Directed testbench for lzw_code_packer: packing, padding flush,
// backpressure, overrun, mid-stream reset and byte-boundary flush.
module tb_lzw_code_packer;

    logic        clk;
    logic        rst;
    logic [11:0] code_in;
    logic        code_valid;
    logic        code_ready;
    logic        flush;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic        done;
    logic        overrun;
    logic [15:0] byte_count;
    logic [15:0] code_count;

    int          assert_count;
    int          fail_count;
    int          cyc;
    int          last_xfer_cycle;
    int          done_cycle;
    int          stable;
    logic [7:0]  got_q[$];
    logic [7:0]  exp_q[$];

    lzw_code_packer #(
        .CODE_WIDTH(12),
        .CNT_WIDTH (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .code_in   (code_in),
        .code_valid(code_valid),
        .code_ready(code_ready),
        .flush     (flush),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .done      (done),
        .overrun   (overrun),
        .byte_count(byte_count),
        .code_count(code_count)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle index of each rising edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Record every byte handed off; sampled mid-cycle ahead of the edge that completes the transfer.
    always @(negedge clk) begin
        if (rst && byte_valid && byte_ready) begin
            got_q.push_back(byte_data);
            last_xfer_cycle = cyc + 1;
        end
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [11:0] code);
        int waited;
        waited = 0;
        while (!code_ready && waited < 40) begin
            tick();
            waited++;
        end
        if (!code_ready) begin
            checkOutput("code_ready_timeout", 32'(code_ready), 32'd1);
        end
        code_in    = code;
        code_valid = 1'b1;
        tick();
        code_valid = 1'b0;
    endtask

    task automatic resetDut(input string tag);
        rst        = 1'b0;
        code_valid = 1'b0;
        flush      = 1'b0;
        byte_ready = 1'b0;
        code_in    = '0;
        #1;
        checkOutput({tag, "_rst_valid"}, 32'(byte_valid), 32'd0);
        checkOutput({tag, "_rst_data"}, 32'(byte_data), 32'd0);
        checkOutput({tag, "_rst_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_rst_overrun"}, 32'(overrun), 32'd0);
        checkOutput({tag, "_rst_counts"}, {byte_count, code_count}, 32'd0);
        tick();
        tick();
        got_q.delete();
        rst = 1'b1;
        tick();
    endtask

    task automatic waitBytes(input int n);
        for (int i = 0; i < 100; i++) begin
            if (got_q.size() >= n) break;
            tick();
        end
    endtask

    task automatic waitDone();
        done_cycle = -1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (done) begin
                done_cycle = cyc;
                break;
            end
        end
    endtask

    task automatic checkStream(input string tag);
        checkOutput({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                checkOutput($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
            end
        end
    endtask

    // Directed scenarios with hand-computed byte streams.
    initial begin
        clk             = 1'b0;
        cyc             = 0;
        assert_count    = 0;
        fail_count      = 0;
        last_xfer_cycle = -1;
        done_cycle      = -1;

        // Packing: ABC DEF -> AB CD EF, first byte two cycles after accept.
        resetDut("pack");
        byte_ready = 1'b1;
        code_in    = 12'hABC;
        code_valid = 1'b1;
        tick();
        code_valid = 1'b0;
        checkOutput("pack_lat1_valid", 32'(byte_valid), 32'd0);
        tick();
        checkOutput("pack_lat2_valid", 32'(byte_valid), 32'd1);
        checkOutput("pack_lat2_data", 32'(byte_data), 32'hAB);
        applyStimulus(12'hDEF);
        waitBytes(3);
        repeat (3) tick();
        exp_q = '{8'hAB, 8'hCD, 8'hEF};
        checkStream("pack");
        checkOutput("pack_code_count", 32'(code_count), 32'd2);
        checkOutput("pack_byte_count", 32'(byte_count), 32'd3);
        checkOutput("pack_done", 32'(done), 32'd0);

        // Flush with padding: 123 -> 12 30; flush held two cycles.
        resetDut("pad");
        byte_ready = 1'b1;
        applyStimulus(12'h123);
        repeat (4) tick();
        flush = 1'b1;
        tick();
        tick();
        flush = 1'b0;
        waitDone();
        exp_q = '{8'h12, 8'h30};
        checkStream("pad");
        checkOutput("pad_done", 32'(done), 32'd1);
        checkOutput("pad_done_timing", 32'(done_cycle - last_xfer_cycle), 32'd1);
        checkOutput("pad_byte_count", 32'(byte_count), 32'd2);

        // Backpressure: first byte held while byte_ready is low.
        resetDut("bp");
        applyStimulus(12'h001);
        applyStimulus(12'h002);
        stable = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (byte_valid && byte_data == 8'h00 && !code_ready) stable++;
        end
        checkOutput("bp_stable", 32'(stable), 32'd10);
        checkOutput("bp_held_count", 32'(byte_count), 32'd0);
        byte_ready = 1'b1;
        applyStimulus(12'h003);
        applyStimulus(12'h004);
        waitBytes(6);
        repeat (3) tick();
        exp_q = '{8'h00, 8'h10, 8'h02, 8'h00, 8'h30, 8'h04};
        checkStream("bp");
        checkOutput("bp_code_count", 32'(code_count), 32'd4);
        checkOutput("bp_byte_count", 32'(byte_count), 32'd6);
        checkOutput("bp_overrun", 32'(overrun), 32'd0);

        // Overrun: back-to-back code strobes, second one is dropped.
        resetDut("ovr");
        byte_ready = 1'b1;
        code_in    = 12'h111;
        code_valid = 1'b1;
        tick();
        code_in = 12'h222;
        tick();
        code_valid = 1'b0;
        tick();
        checkOutput("ovr_flag", 32'(overrun), 32'd1);
        checkOutput("ovr_code_count", 32'(code_count), 32'd1);
        waitBytes(1);
        repeat (2) tick();
        exp_q = '{8'h11};
        checkStream("ovr");

        // Reset mid-stream with a byte held and 4 bits pending.
        resetDut("mid");
        applyStimulus(12'hABC);
        tick();
        checkOutput("mid_pre_valid", 32'(byte_valid), 32'd1);
        checkOutput("mid_pre_code_count", 32'(code_count), 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("mid_async_valid", 32'(byte_valid), 32'd0);
        checkOutput("mid_async_data", 32'(byte_data), 32'd0);
        checkOutput("mid_async_code_count", 32'(code_count), 32'd0);
        tick();
        got_q.delete();
        rst = 1'b1;
        tick();
        byte_ready = 1'b1;
        applyStimulus(12'hFFF);
        repeat (3) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        waitDone();
        exp_q = '{8'hFF, 8'hF0};
        checkStream("mid");
        checkOutput("mid_done", 32'(done), 32'd1);

        // Flush on a byte boundary: no pad byte, then DONE ignores new codes.
        resetDut("bnd");
        byte_ready = 1'b1;
        applyStimulus(12'h0A0);
        applyStimulus(12'h5B5);
        waitBytes(3);
        repeat (2) tick();
        checkOutput("bnd_idle_valid", 32'(byte_valid), 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("bnd_done_early", 32'(done), 32'd0);
        tick();
        checkOutput("bnd_done", 32'(done), 32'd1);
        code_in    = 12'h777;
        code_valid = 1'b1;
        flush      = 1'b1;
        tick();
        code_valid = 1'b0;
        flush      = 1'b0;
        repeat (3) tick();
        exp_q = '{8'h0A, 8'h05, 8'hB5};
        checkStream("bnd");
        checkOutput("bnd_overrun", 32'(overrun), 32'd1);
        checkOutput("bnd_code_count", 32'(code_count), 32'd2);
        checkOutput("bnd_byte_count", 32'(byte_count), 32'd3);
        checkOutput("bnd_done_sticky", 32'(done), 32'd1);
        checkOutput("bnd_code_ready", 32'(code_ready), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
